// File: rtl/lights_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lights_out_pkg
//  Purpose  : Shared types and helpers for the Lights Out board controller:
//             grid geometry, FSM state and move-step encodings, and the
//             mapping from (cursor, step) to the board cell a step touches.
//  Revision : 1.0  initial release
// ============================================================================
package lights_out_pkg;

    localparam int GRID_DIM = 8;
    localparam int CELLS    = GRID_DIM * GRID_DIM;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        APPLY    = 3'd1,
        CHECK    = 3'd2,
        WON      = 3'd3,
        SCRAMBLE = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CENTRE = 3'd0,
        LEFT   = 3'd1,
        RIGHT  = 3'd2,
        UP     = 3'd3,
        DOWN   = 3'd4
    } step_t;

    // Cell a move step targets, and whether that cell lies on the board.
    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
    } cell_sel_t;

    // Linear cell index, row*8+col.
    function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

    // Target cell for one step of a move centred on pos ([5:3] row, [2:0] col).
    // Edge cells mark their missing neighbour invalid; the wrapped index
    // is then never written.
    function automatic cell_sel_t step_cell(input logic [5:0] pos, input step_t step);
        logic [2:0] row;
        logic [2:0] col;
        cell_sel_t  sel;
        row       = pos[5:3];
        col       = pos[2:0];
        sel.valid = 1'b1;
        sel.idx   = cell_idx(row, col);
        case (step)
            LEFT: begin
                sel.valid = (col != 3'd0);
                sel.idx   = cell_idx(row, col - 3'd1);
            end
            RIGHT: begin
                sel.valid = (col != 3'(GRID_DIM - 1));
                sel.idx   = cell_idx(row, col + 3'd1);
            end
            UP: begin
                sel.valid = (row != 3'd0);
                sel.idx   = cell_idx(row - 3'd1, col);
            end
            DOWN: begin
                sel.valid = (row != 3'(GRID_DIM - 1));
                sel.idx   = cell_idx(row + 3'd1, col);
            end
            default: begin
                sel.valid = 1'b1;
                sel.idx   = cell_idx(row, col);
            end
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lights_out_board_ctrl_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : lights_out_lfsr
//  Purpose  : 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1,
//             shifting right with the feedback entering at bit 15. Provides
//             pseudo-random cursor positions for board scrambling.
//  Revision : 1.0  initial release
// ============================================================================
module lights_out_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [15:0] o_state
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    // Taps 16,14,13,11 expressed on the right-shifting register.
    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Shift register; a nonzero seed keeps it out of the lock-up state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

    assign o_state = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/lights_out_board_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lights_out_board_ctrl
//  Purpose  : Holds the 8x8 Lights Out board and sequences each move one
//             cell write per cycle (centre, left, right, up, down), with
//             move counting, win detection and new-game loading.
//  Config   : LIGHTS_OUT_SCRAMBLE_EN - when defined, New_game scrambles the
//             freshly loaded board with SCRAMBLE_MOVES LFSR-driven moves.
//  Revision : 1.0  initial release
// ============================================================================
module lights_out_board_ctrl
    import lights_out_pkg::*;
#(
    parameter logic [CELLS-1:0] INIT_PATTERN   = 64'h0000_0018_1800_0000,
    parameter int               SCRAMBLE_MOVES = 20,
    parameter logic [15:0]      LFSR_SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Toggle,
    input  logic [5:0]       Position,
    input  logic             New_game,
    output logic [CELLS-1:0] Board,
    output logic             Busy,
    output logic             Won,
    output logic [9:0]       Move_count
);

    localparam logic [9:0] C_CNT_MAX = 10'h3FF;

    state_t           r_state;
    state_t           w_state_nxt;
    step_t            r_step;
    step_t            w_step_nxt;
    logic [5:0]       r_pos;
    logic [5:0]       w_pos_nxt;
    logic [CELLS-1:0] r_board;
    logic             r_won;
    logic             w_won_nxt;
    logic [9:0]       r_move_cnt;
    logic             r_toggle_q;
    logic             w_edge;
    logic             w_load;
    logic             w_cnt_inc;
    logic             w_cell_wr;
    cell_sel_t        w_sel;

`ifdef LIGHTS_OUT_SCRAMBLE_EN
    localparam int C_SCR_W = $clog2(SCRAMBLE_MOVES + 1);

    logic [C_SCR_W-1:0] r_scr_left;
    logic [C_SCR_W-1:0] w_scr_left_nxt;
    logic               r_scr_mode;
    logic               w_scr_mode_nxt;
    logic [15:0]        w_lfsr;
    logic               w_lfsr_unused;

    // Free-running source of scramble positions.
    lights_out_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (reset),
        .i_en    (1'b1),
        .o_state (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr[15:6];
`else
    logic w_cfg_unused;
    assign w_cfg_unused = ^{LFSR_SEED, SCRAMBLE_MOVES};
`endif

    assign w_edge = Toggle & ~r_toggle_q;
    assign w_sel  = step_cell(r_pos, r_step);

    // Next-state and datapath control; New_game overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_pos_nxt   = r_pos;
        w_won_nxt   = r_won;
        w_load      = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cell_wr   = 1'b0;
`ifdef LIGHTS_OUT_SCRAMBLE_EN
        w_scr_left_nxt = r_scr_left;
        w_scr_mode_nxt = r_scr_mode;
`endif
        if (New_game) begin
            w_load     = 1'b1;
            w_won_nxt  = 1'b0;
            w_step_nxt = CENTRE;
`ifdef LIGHTS_OUT_SCRAMBLE_EN
            w_state_nxt    = SCRAMBLE;
            w_scr_left_nxt = C_SCR_W'(SCRAMBLE_MOVES);
            w_scr_mode_nxt = 1'b1;
`else
            w_state_nxt = CHECK;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        w_pos_nxt   = Position;
                        w_cnt_inc   = 1'b1;
                        w_step_nxt  = CENTRE;
                        w_state_nxt = APPLY;
                    end
                end
                APPLY: begin
                    // Off-board steps still spend their cycle, keeping the
                    // move length fixed.
                    w_cell_wr = w_sel.valid;
                    if (r_step == DOWN) begin
                        w_step_nxt  = CENTRE;
                        w_state_nxt = CHECK;
`ifdef LIGHTS_OUT_SCRAMBLE_EN
                        if (r_scr_left != '0) begin
                            w_state_nxt = SCRAMBLE;
                        end
`endif
                    end else begin
                        w_step_nxt = step_t'(r_step + 3'd1);
                    end
                end
                CHECK: begin
                    w_won_nxt   = (r_board == '0);
                    w_state_nxt = (r_board == '0) ? WON : IDLE;
`ifdef LIGHTS_OUT_SCRAMBLE_EN
                    // A scramble that lands on a dark board is not a win.
                    if (r_scr_mode) begin
                        w_won_nxt      = 1'b0;
                        w_state_nxt    = IDLE;
                        w_scr_mode_nxt = 1'b0;
                    end
`endif
                end
                WON: begin
                    w_state_nxt = WON;
                end
`ifdef LIGHTS_OUT_SCRAMBLE_EN
                SCRAMBLE: begin
                    w_pos_nxt      = w_lfsr[5:0];
                    w_scr_left_nxt = r_scr_left - C_SCR_W'(1);
                    w_step_nxt     = CENTRE;
                    w_state_nxt    = APPLY;
                end
`endif
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Board, move latch, counters and edge detector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step     <= CENTRE;
            r_pos      <= '0;
            r_board    <= INIT_PATTERN;
            r_won      <= 1'b0;
            r_move_cnt <= '0;
            r_toggle_q <= 1'b0;
        end else begin
            r_toggle_q <= Toggle;
            r_step     <= w_step_nxt;
            r_pos      <= w_pos_nxt;
            r_won      <= w_won_nxt;
            if (New_game) begin
                r_move_cnt <= '0;
            end else if (w_cnt_inc && (r_move_cnt != C_CNT_MAX)) begin
                r_move_cnt <= r_move_cnt + 10'd1;
            end
            if (w_load) begin
                r_board <= INIT_PATTERN;
            end else if (w_cell_wr) begin
                r_board[w_sel.idx] <= ~r_board[w_sel.idx];
            end
        end
    end

`ifdef LIGHTS_OUT_SCRAMBLE_EN
    // Scramble bookkeeping: moves still to run, and whether the pending
    // CHECK closes a scramble rather than a player move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scr_left <= '0;
            r_scr_mode <= 1'b0;
        end else begin
            r_scr_left <= w_scr_left_nxt;
            r_scr_mode <= w_scr_mode_nxt;
        end
    end
`endif

    assign Board      = r_board;
    assign Won        = r_won;
    assign Move_count = r_move_cnt;
    assign Busy       = (r_state == APPLY) || (r_state == CHECK) || (r_state == SCRAMBLE);

endmodule
`default_nettype wire
